// File: rtl/apb_master_engine.sv
// -----------------------------------------------------------------------------
// apb_master_engine
//   Parametrised APB master. Read/write commands are queued in a small FIFO,
//   each one optionally preceded by a programmable number of idle cycles, then
//   driven as a full APB SETUP/ACCESS transfer that honours pready wait states
//   and pslverr. Exactly one response is returned per command through a
//   single valid/ready response register.
//
//   Build option:
//     APB_TIMEOUT_EN - when defined, an ACCESS phase that sees pready=0 for
//                      TIMEOUT_CYC cycles is aborted and answered with
//                      rsp_slverr=1, rsp_timeout=1, rsp_rdata=0. When
//                      undefined, ACCESS waits indefinitely and rsp_timeout
//                      is tied low.
//
//   Ports
//     pclk, preset               clock (rising edge), async active-high reset
//     cmd_valid / cmd_ready      command handshake (cmd_ready = FIFO not full)
//     cmd_write, cmd_addr,       command payload: direction, address,
//     cmd_wdata, cmd_delay       write data, idle cycles before SETUP
//     rsp_valid / rsp_ready      response handshake (held until accepted)
//     rsp_rdata, rsp_slverr,     read data (0 for writes), slave error,
//     rsp_timeout                transfer aborted by timeout
//     psel, penable, pwrite,     APB requester signals
//     paddr, pwdata
//     prdata, pready, pslverr    APB completer signals
//     busy                       FSM active, FIFO non-empty or response pending
// -----------------------------------------------------------------------------
module apb_master_engine #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int CMD_DEPTH   = 4,
   parameter int DLY_W       = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [DLY_W-1:0]  cmd_delay,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_slverr,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr,
   output logic              busy
);

   localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int CMD_W = 1 + ADDR_W + DATA_W + DLY_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DELAY,
      S_SETUP,
      S_ACCESS
   } state_t;

   // ---------------------------------------------------------------- FIFO
   logic [CMD_W-1:0] fifo_mem [CMD_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;

   logic              head_write;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_wdata;
   logic [DLY_W-1:0]  head_delay;

   // ----------------------------------------------------------------- FSM
   state_t            state_q;
   logic [DLY_W-1:0]  dly_cnt_q;
   logic              hold_write_q;
   logic [ADDR_W-1:0] hold_addr_q;
   logic [DATA_W-1:0] hold_wdata_q;
   logic              psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_slverr_q;

`ifdef APB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] wait_cnt_q;
   logic            rsp_timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

   assign fifo_full  = (count_q == CNT_W'(CMD_DEPTH));
   assign fifo_empty = (count_q == '0);

   // Full is judged on the registered count, so a pop in the same cycle
   // never opens a slot for a simultaneous push.
   assign push = cmd_valid && !fifo_full;

   // A command may only start when the response register is free or is
   // being emptied in this very cycle.
   assign pop = (state_q == S_IDLE) && !fifo_empty && (!rsp_valid_q || rsp_ready);

   assign {head_write, head_addr, head_wdata, head_delay} = fifo_mem[rd_ptr_q];

   // Storage has no reset: contents are only ever read behind a non-zero count.
   always_ff @(posedge pclk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata, cmd_delay};
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Transfer sequencer. All APB and response outputs are registered here.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q      <= S_IDLE;
         dly_cnt_q    <= '0;
         hold_write_q <= 1'b0;
         hold_addr_q  <= '0;
         hold_wdata_q <= '0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_slverr_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
         wait_cnt_q    <= '0;
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         // Consumed response clears unless a completion below reloads it.
         if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  hold_write_q <= head_write;
                  hold_addr_q  <= head_addr;
                  hold_wdata_q <= head_write ? head_wdata : '0;
                  if (head_delay == '0) begin
                     psel_q   <= 1'b1;
                     pwrite_q <= head_write;
                     paddr_q  <= head_addr;
                     pwdata_q <= head_write ? head_wdata : '0;
                     state_q  <= S_SETUP;
                  end else begin
                     dly_cnt_q <= head_delay;
                     state_q   <= S_DELAY;
                  end
               end
            end

            S_DELAY: begin
               // Counter value N means N idle cycles remain including this one.
               if (dly_cnt_q == DLY_W'(1)) begin
                  psel_q   <= 1'b1;
                  pwrite_q <= hold_write_q;
                  paddr_q  <= hold_addr_q;
                  pwdata_q <= hold_wdata_q;
                  state_q  <= S_SETUP;
               end else begin
                  dly_cnt_q <= dly_cnt_q - DLY_W'(1);
               end
            end

            S_SETUP: begin
               penable_q <= 1'b1;
               state_q   <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
               wait_cnt_q <= '0;
`endif
            end

            S_ACCESS: begin
               if (pready) begin
                  psel_q       <= 1'b0;
                  penable_q    <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  rsp_rdata_q  <= pwrite_q ? '0 : prdata;
                  rsp_slverr_q <= pslverr;
                  state_q      <= S_IDLE;
`ifdef APB_TIMEOUT_EN
                  rsp_timeout_q <= 1'b0;
`endif
               end
`ifdef APB_TIMEOUT_EN
               else if (wait_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                  // Last permitted wait cycle without pready: abandon the transfer.
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= '0;
                  rsp_slverr_q  <= 1'b1;
                  rsp_timeout_q <= 1'b1;
                  state_q       <= S_IDLE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + TO_W'(1);
               end
`endif
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready  = !fifo_full;
   assign psel       = psel_q;
   assign penable    = penable_q;
   assign pwrite     = pwrite_q;
   assign paddr      = paddr_q;
   assign pwdata     = pwdata_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_slverr = rsp_slverr_q;
`ifdef APB_TIMEOUT_EN
   assign rsp_timeout = rsp_timeout_q;
`else
   assign rsp_timeout = 1'b0;
`endif
   assign busy = (state_q != S_IDLE) || !fifo_empty || rsp_valid_q;

endmodule

// File: tb/tb_apb_master_engine.sv
module tb_apb_master_engine;

   localparam int TIMEOUT_CYC = 16;

   logic        pclk = 1'b0;
   logic        preset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_delay = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_slverr;
   logic        rsp_timeout;
   logic        psel, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata = '0;
   logic        pready = 1'b0;
   logic        pslverr = 1'b0;
   logic        busy;

   always #5 pclk = ~pclk;

   apb_master_engine #(
      .ADDR_W(8), .DATA_W(32), .CMD_DEPTH(4), .DLY_W(4), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_delay(cmd_delay),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
   );

   typedef struct { logic wr; logic [7:0] addr; logic [31:0] wdata; logic [3:0] dly; } cmd_t;
   typedef struct { logic [31:0] rdata; logic err; logic to; } rsp_t;
   typedef struct {
      logic wr; logic [7:0] addr; logic [31:0] wdata; logic [3:0] dly;
      logic [31:0] exp_rdata; logic exp_err;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   cmd_t cmd_q[$];
   rsp_t exp_q[$];

   logic [31:0] slv_mem   [256];
   logic [31:0] model_mem [256];
   int slv_ws = 0;          // fixed wait states; negative = random 0..3 per transfer

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   function automatic logic [31:0] init_val(input logic [7:0] a);
      return 32'hA5A5_A500 | {24'h0, a};
   endfunction

   // Environment rule: the upper address page 0xF0-0xFF answers with an error.
   function automatic logic addr_err(input logic [7:0] a);
      return a[7:4] == 4'hF;
   endfunction

   task automatic init_mem();
      for (int i = 0; i < 256; i++) begin
         slv_mem[i]   = init_val(8'(i));
         model_mem[i] = init_val(8'(i));
      end
   endtask

   // Reference: responses follow command order; reads see all earlier
   // successful writes, writes return zero data, errors come from the page rule.
   function automatic rsp_t model(input cmd_t c);
      rsp_t r;
      r.to  = 1'b0;
      r.err = addr_err(c.addr);
      if (c.wr) begin
         r.rdata = '0;
         if (!r.err) model_mem[c.addr] = c.wdata;
      end else begin
         r.rdata = model_mem[c.addr];
      end
      return r;
   endfunction

   // ------------------------------------------------------- APB completer
   int          cur_ws;
   int          acc_cnt;
   logic [40:0] setup_snap;

   always @(negedge pclk) begin
      pready  = 1'b0;
      pslverr = 1'($urandom);
      prdata  = $urandom;
      if (!preset && psel && !penable) begin
         cur_ws     = (slv_ws < 0) ? int'($urandom_range(0, 3)) : slv_ws;
         acc_cnt    = 0;
         setup_snap = {paddr, pwrite, pwdata};
         if (!pwrite) check("setup_read_pwdata", 64'(pwdata), 64'h0);
      end else if (!preset && psel && penable) begin
         check("access_stable", 64'({paddr, pwrite, pwdata}), 64'(setup_snap));
         if (acc_cnt >= cur_ws) begin
            pready  = 1'b1;
            pslverr = addr_err(paddr);
            if (!pwrite) prdata = slv_mem[paddr];
            else if (!pslverr) slv_mem[paddr] = pwdata;
         end
         acc_cnt++;
      end
   end

   // ------------------------------------------------------------- helpers
   task automatic drive_cmd(input cmd_t c);
      cmd_write = c.wr;
      cmd_addr  = c.addr;
      cmd_wdata = c.wdata;
      cmd_delay = c.dly;
   endtask

   task automatic check_rsp(input string tag, input rsp_t e);
      check({tag, "_rdata"},   64'(rsp_rdata),   64'(e.rdata));
      check({tag, "_slverr"},  64'(rsp_slverr),  64'(e.err));
      check({tag, "_timeout"}, 64'(rsp_timeout), 64'(e.to));
   endtask

   // One isolated command; reports cycles from accept edge to psel rise and
   // number of sampled cycles with penable high.
   task automatic single(input string tag, input cmd_t c, input rsp_t e,
                         output int lat, output int en);
      int  k = 0;
      bit  seen = 0;
      lat = -1;
      en  = 0;
      drive_cmd(c);
      cmd_valid = 1'b1;
      rsp_ready = 1'b0;
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'h1);
      tick();
      cmd_valid = 1'b0;
      while (!rsp_valid && k < 100) begin
         tick();
         k++;
         if (psel && !seen) begin seen = 1; lat = k; end
         if (penable) en++;
      end
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'h1);
      check_rsp(tag, e);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, "_rsp_clear"}, 64'(rsp_valid), 64'h0);
   endtask

   // Streams cmd_q into the DUT while draining responses against exp_q.
   task automatic run_stream(input string tag, input int valid_pct, input int ready_pct,
                             input bit use_model);
      int   budget = 5000;
      int   idx = 0;
      bit   do_push, do_pop;
      rsp_t e;
      while ((cmd_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
         if (cmd_q.size() > 0 && int'($urandom_range(1, 100)) <= valid_pct) begin
            drive_cmd(cmd_q[0]);
            cmd_valid = 1'b1;
         end else begin
            cmd_valid = 1'b0;
         end
         rsp_ready = (int'($urandom_range(1, 100)) <= ready_pct);
         do_push = cmd_valid && cmd_ready;
         do_pop  = rsp_valid && rsp_ready;
         if (do_pop) begin
            check($sformatf("%s_rsp%0d_expected", tag, idx), 64'(exp_q.size() > 0), 64'h1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_rsp($sformatf("%s_rsp%0d", tag, idx), e);
            end
            idx++;
         end
         if (do_push) begin
            if (use_model) exp_q.push_back(model(cmd_q[0]));
            cmd_q.delete(0);
         end
         tick();
         budget--;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      check({tag, "_within_budget"}, 64'(budget > 0), 64'h1);
   endtask

   task automatic wait_rsp(input string tag);
      int k = 0;
      while (!rsp_valid && k < 50) begin tick(); k++; end
      check({tag, "_wait"}, 64'(rsp_valid), 64'h1);
   endtask

   // ---------------------------------------------------------------- test
   vec_t tbl[10];

   initial begin
      int   lat, en, seen;
      cmd_t c;
      rsp_t e;

      tbl[0] = '{1'b1, 8'h08, 32'hDEADBEEF, 4'd0, 32'h0,        1'b0};
      tbl[1] = '{1'b1, 8'h0C, 32'h12345678, 4'd2, 32'h0,        1'b0};
      tbl[2] = '{1'b0, 8'h08, 32'h0,        4'd0, 32'hDEADBEEF, 1'b0};
      tbl[3] = '{1'b0, 8'h0C, 32'h0,        4'd1, 32'h12345678, 1'b0};
      tbl[4] = '{1'b1, 8'hF0, 32'hCAFEF00D, 4'd0, 32'h0,        1'b1};
      tbl[5] = '{1'b0, 8'hF0, 32'h0,        4'd3, 32'hA5A5A5F0, 1'b1};
      tbl[6] = '{1'b0, 8'h20, 32'h0,        4'd0, 32'hA5A5A520, 1'b0};
      tbl[7] = '{1'b1, 8'h20, 32'h00000000, 4'd0, 32'h0,        1'b0};
      tbl[8] = '{1'b0, 8'h20, 32'h0,        4'd1, 32'h00000000, 1'b0};
      tbl[9] = '{1'b0, 8'hFF, 32'h0,        4'd0, 32'hA5A5A5FF, 1'b1};

      init_mem();
      #2 preset = 1'b1;
      tick();
      tick();
      check("rst_cmd_ready", 64'(cmd_ready), 64'h1);
      check("rst_psel",      64'(psel),      64'h0);
      check("rst_penable",   64'(penable),   64'h0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      check("rst_busy",      64'(busy),      64'h0);
      check("rst_paddr",     64'(paddr),     64'h0);
      check("rst_pwdata",    64'(pwdata),    64'h0);
      check("rst_rdata",     64'(rsp_rdata), 64'h0);
      preset = 1'b0;
      tick();

      // Test 1: write latency, cycle by cycle
      slv_ws = 0;
      drive_cmd('{1'b1, 8'h08, 32'hDEADBEEF, 4'd0});
      cmd_valid = 1'b1;
      tick();                                   // E0
      cmd_valid = 1'b0;
      check("t1_psel_E0", 64'(psel), 64'h0);
      tick();                                   // E1
      check("t1_psel_E1",    64'(psel),    64'h1);
      check("t1_penable_E1", 64'(penable), 64'h0);
      check("t1_paddr",      64'(paddr),   64'h08);
      check("t1_pwrite",     64'(pwrite),  64'h1);
      check("t1_pwdata",     64'(pwdata),  64'hDEADBEEF);
      check("t1_rsp_E1",     64'(rsp_valid), 64'h0);
      tick();                                   // E2
      check("t1_penable_E2", 64'(penable), 64'h1);
      check("t1_rsp_E2",     64'(rsp_valid), 64'h0);
      tick();                                   // E3
      check("t1_rsp_E3",     64'(rsp_valid), 64'h1);
      check("t1_psel_E3",    64'(psel),      64'h0);
      check("t1_penable_E3", 64'(penable),   64'h0);
      check_rsp("t1", '{32'h0, 1'b0, 1'b0});
      check("t1_pwdata_hold", 64'(pwdata),   64'hDEADBEEF);
      tick();
      check("t1_rsp_held", 64'(rsp_valid), 64'h1);
      check("t1_busy",     64'(busy),      64'h1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("t1_rsp_clear", 64'(rsp_valid), 64'h0);
      check("t1_idle",      64'(busy),      64'h0);

      // Test 2: read with three wait states
      single("t2w", '{1'b1, 8'h0C, 32'h12345678, 4'd0}, '{32'h0, 1'b0, 1'b0}, lat, en);
      check("t2w_psel_lat", 64'(lat), 64'd1);
      check("t2w_penable",  64'(en),  64'd1);
      slv_ws = 3;
      single("t2r", '{1'b0, 8'h0C, 32'h0, 4'd0}, '{32'h12345678, 1'b0, 1'b0}, lat, en);
      check("t2r_penable", 64'(en), 64'd4);
      slv_ws = 0;

      // Test 4: idle delay before SETUP
      single("t4", '{1'b0, 8'h05, 32'h0, 4'd5}, '{init_val(8'h05), 1'b0, 1'b0}, lat, en);
      check("t4_psel_lat", 64'(lat), 64'd6);
      single("t4max", '{1'b0, 8'h06, 32'h0, 4'd15}, '{init_val(8'h06), 1'b0, 1'b0}, lat, en);
      check("t4max_psel_lat", 64'(lat), 64'd16);

      // Table vectors (includes error write followed by a normal read)
      init_mem();
      slv_ws = -1;
      for (int i = 0; i < 10; i++) begin
         c = '{tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].dly};
         e = '{tbl[i].exp_rdata, tbl[i].exp_err, 1'b0};
         single($sformatf("tbl%0d", i), c, e, lat, en);
         check($sformatf("tbl%0d_psel_lat", i), 64'(lat), 64'(tbl[i].dly) + 64'd1);
      end

      // Test 3: response back-pressure fills the FIFO
      init_mem();
      slv_ws = 0;
      drive_cmd('{1'b1, 8'h30, 32'h11111111, 4'd0});
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      wait_rsp("t3a");
      cmd_q = '{};
      cmd_q.push_back('{1'b0, 8'h30, 32'h0,        4'd0});
      cmd_q.push_back('{1'b1, 8'h31, 32'h22222222, 4'd1});
      cmd_q.push_back('{1'b0, 8'h31, 32'h0,        4'd0});
      cmd_q.push_back('{1'b0, 8'hF1, 32'h0,        4'd0});
      for (int i = 0; i < 4; i++) begin
         drive_cmd(cmd_q[i]);
         cmd_valid = 1'b1;
         check($sformatf("t3_push%0d_ready", i), 64'(cmd_ready), 64'h1);
         tick();
      end
      cmd_q = '{};
      drive_cmd('{1'b1, 8'h30, 32'h0BAD0BAD, 4'd0});   // fifth: must be refused
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t3_full%0d", i),  64'(cmd_ready), 64'h0);
         check($sformatf("t3_stall%0d", i), 64'(psel),      64'h0);
         check($sformatf("t3_held%0d", i),  64'(rsp_valid), 64'h1);
         tick();
      end
      check("t3_busy", 64'(busy), 64'h1);
      exp_q = '{};
      exp_q.push_back('{32'h11111111, 1'b0, 1'b0});
      exp_q.push_back('{32'h0,        1'b0, 1'b0});
      exp_q.push_back('{32'h22222222, 1'b0, 1'b0});
      exp_q.push_back('{32'hA5A5A5F1, 1'b1, 1'b0});
      rsp_ready = 1'b1;
      check("t3_full_on_pop", 64'(cmd_ready), 64'h0);
      check_rsp("t3a", '{32'h0, 1'b0, 1'b0});
      tick();
      cmd_valid = 1'b0;
      run_stream("t3", 0, 100, 1'b0);
      seen = 0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (rsp_valid) seen++;
         tick();
      end
      rsp_ready = 1'b0;
      check("t3_no_extra_rsp", 64'(seen), 64'h0);
      check("t3_idle", 64'(busy), 64'h0);

      // Randomised stream against the reference model
      init_mem();
      slv_ws = -1;
      cmd_q = '{};
      exp_q = '{};
      for (int i = 0; i < 40; i++) begin
         c.wr    = 1'($urandom);
         c.addr  = ($urandom_range(0, 3) == 0) ? (8'hF0 | 8'($urandom_range(0, 3)))
                                               : 8'($urandom_range(0, 7));
         c.wdata = $urandom;
         c.dly   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
         cmd_q.push_back(c);
      end
      run_stream("rnd", 80, 70, 1'b1);
      check("rnd_idle", 64'(busy), 64'h0);

`ifdef APB_TIMEOUT_EN
      // Test 6a: stuck pready aborts after TIMEOUT_CYC access cycles
      slv_ws = 1000;
      single("t6to", '{1'b0, 8'h44, 32'h0, 4'd0}, '{32'h0, 1'b1, 1'b1}, lat, en);
      check("t6to_penable", 64'(en), 64'(TIMEOUT_CYC));
      slv_ws = 0;
`endif

      // Test 6b: reset in the middle of ACCESS
      slv_ws = 1000;
      drive_cmd('{1'b0, 8'h40, 32'h0, 4'd0});
      cmd_valid = 1'b1;
      tick();
      drive_cmd('{1'b1, 8'h41, 32'h55AA55AA, 4'd0});
      tick();
      cmd_valid = 1'b0;
      for (int k = 0; k < 10 && !penable; k++) tick();
      check("t6_in_access", 64'(penable), 64'h1);
      tick();
      #2 preset = 1'b1;
      #1;
      check("t6_rst_psel",      64'(psel),      64'h0);
      check("t6_rst_penable",   64'(penable),   64'h0);
      check("t6_rst_rsp_valid", 64'(rsp_valid), 64'h0);
      check("t6_rst_cmd_ready", 64'(cmd_ready), 64'h1);
      check("t6_rst_busy",      64'(busy),      64'h0);
      tick();
      tick();
      preset = 1'b0;
      slv_ws = 0;
      seen = 0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid || psel) seen++;
         tick();
      end
      rsp_ready = 1'b0;
      check("t6_discarded", 64'(seen), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
